// File: rtl/timer_device.sv
// Memory-mapped countdown timer.
// Word map: 0=CTRL {IM, Mode[1:0], Enable}, 1=PRESET, 2=COUNT (read-only), 3=unused.
// Mode 0 is one-shot with a latched interrupt flag; mode 1 is auto-reload
// with a single-cycle interrupt pulse. Mode values 1x behave as mode 0.
// Optional feature: define TIMER_PRESCALE_EN to build a divider so COUNT
// advances once every PRESCALE cycles; otherwise every CNT cycle is a tick.
module timer_device #(
  parameter int unsigned PRESCALE = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  Addr,
  input  logic        WE,
  input  logic [31:0] DataIn,
  output logic [31:0] DataOut,
  output logic        IRQ
);

  // state | meaning
  // IDLE  | stopped, waiting for Enable
  // LOAD  | copy PRESET into COUNT
  // CNT   | counting down on each tick
  // INT   | terminal count reached, raise the interrupt flag
  typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;

  state_t      state, state_nxt;
  logic        ctrl_en;
  logic [1:0]  ctrl_mode;
  logic        ctrl_im;
  logic [31:0] preset;
  logic [31:0] count;
  logic        irq_flag;
  logic        wr_ctrl, wr_preset;
  logic        mode_reload;
  logic        count_last;
  logic        tick;

  if (PRESCALE < 1) begin : g_prescale_check
    $error("timer_device: PRESCALE must be at least 1");
  end

  assign wr_ctrl     = WE && (Addr == 2'd0);
  assign wr_preset   = WE && (Addr == 2'd1);
  assign mode_reload = (ctrl_mode == 2'b01);
  // COUNT<=1 ends the run, so a PRESET of 0 behaves like 1 and COUNT never wraps.
  assign count_last  = (count <= 32'd1);

`ifdef TIMER_PRESCALE_EN
  localparam int unsigned DIV_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  logic [DIV_W-1:0] div;

  assign tick = (div == DIV_W'(PRESCALE - 1));

  // Divider runs only in CNT and restarts after every tick.
  always_ff @(posedge clk) begin
    if (reset) div <= '0;
    else if ((state != CNT) || tick) div <= '0;
    else div <= div + 1'b1;
  end
`else
  assign tick = 1'b1;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (ctrl_en) state_nxt = LOAD;
      LOAD: state_nxt = CNT;
      CNT: begin
        if (!ctrl_en) state_nxt = IDLE;
        else if (tick && count_last) state_nxt = INT;
      end
      INT: state_nxt = mode_reload ? LOAD : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // CTRL: a bus write always wins over the one-shot auto-disable.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_en   <= 1'b0;
      ctrl_mode <= 2'b00;
      ctrl_im   <= 1'b0;
    end else if (wr_ctrl) begin
      ctrl_en   <= DataIn[0];
      ctrl_mode <= DataIn[2:1];
      ctrl_im   <= DataIn[3];
    end else if ((state == INT) && !mode_reload) begin
      ctrl_en   <= 1'b0;
    end
  end

  // PRESET is only sampled in LOAD, so mid-count writes wait for the next reload.
  always_ff @(posedge clk) begin
    if (reset) preset <= '0;
    else if (wr_preset) preset <= DataIn;
  end

  // COUNT reload and decrement; holds in every other case.
  always_ff @(posedge clk) begin
    if (reset) count <= '0;
    else if (state == LOAD) count <= preset;
    else if ((state == CNT) && ctrl_en && tick) count <= count_last ? 32'd0 : count - 32'd1;
  end

  // Interrupt flag: set in INT, cleared by a CTRL write, self-clearing in mode 1.
  always_ff @(posedge clk) begin
    if (reset) irq_flag <= 1'b0;
    else if (state == INT) irq_flag <= 1'b1;
    else if (wr_ctrl || mode_reload) irq_flag <= 1'b0;
  end

  // Read mux.
  always_comb begin
    DataOut = 32'd0;
    unique case (Addr)
      2'd0: DataOut = {28'd0, ctrl_im, ctrl_mode, ctrl_en};
      2'd1: DataOut = preset;
      2'd2: DataOut = count;
      default: DataOut = 32'd0;
    endcase
  end

  assign IRQ = ctrl_im & irq_flag;

endmodule
